counter_uart_reporter: RTL and testbench

- Downstream consumer of the button-counter stage.
- On each report pulse, it captures the 16-bit press count and converts it to 5 ASCII decimal digits.
- It then transmits a fixed 11-byte message, "BTN=ddddd\r\n", over a UART TX line (8N1, LSB first).
- It provides the UART reporting that the simplified counter top currently lacks.

---
 rtl/counter_uart_reporter_if.sv | 28 ++
 rtl/counter_uart_reporter.sv | 192 +++++++++++++++++++
 tb/tb_counter_uart_reporter.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_uart_reporter_if.sv
// Report request and UART status bundle for counter_uart_reporter.
// The master side drives the count and request; the slave side is the reporter.
interface counter_uart_reporter_if;
  logic [15:0] count_in;
  logic        report;
  logic        uart_tx;
  logic        busy;
  logic        done;
  logic        dropped;

  modport master (
    output count_in,
    output report,
    input  uart_tx,
    input  busy,
    input  done,
    input  dropped
  );

  modport slave (
    input  count_in,
    input  report,
    output uart_tx,
    output busy,
    output done,
    output dropped
  );
endinterface

// File: rtl/counter_uart_reporter.sv
// Captures a 16-bit press count on a report pulse, converts it to five decimal digits with a
// sequential double-dabble, then sends "BTN=ddddd\r\n" as 8N1 UART, LSB first.
// One request can wait in a pending slot while busy; a newer one overwrites it and pulses dropped.
// Optional macro COUNTER_UART_BLANK_ZEROS_EN: leading zero digits d4..d1 are sent as spaces.
module counter_uart_reporter #(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic                    clk_12m,
  input  logic                    rst_n,
  counter_uart_reporter_if.slave  bus
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
  localparam int unsigned BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("counter_uart_reporter: CLK_HZ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StConvert, StSend} state_e;

  state_e          r_state, w_state_d;
  logic            r_tx, r_busy, r_done, r_dropped, r_pend;
  logic [15:0]     r_pend_cnt, r_bin;
  logic [19:0]     r_bcd, w_bcd_adj;
  logic [4:0]      r_cnv;
  logic [BW-1:0]   r_baud;
  logic [3:0]      r_bit, r_byte, w_nbit, w_nbyte;
  logic            w_start, w_cnv_done, w_bit_end, w_msg_end, w_tx_d;
  logic [7:0]      w_chr [5];
  logic [7:0]      w_byte_val;

  // State register.
  always_ff @(posedge clk_12m) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // Next state and the strobes that steer the datapath.
  always_comb begin
    w_state_d  = r_state;
    w_start    = 1'b0;
    w_cnv_done = 1'b0;
    w_bit_end  = 1'b0;
    w_msg_end  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.report) begin
          w_start   = 1'b1;
          w_state_d = StConvert;
        end
      end
      StConvert: begin
        if (r_cnv == 5'd16) begin
          w_cnv_done = 1'b1;
          w_state_d  = StSend;
        end
      end
      StSend: begin
        if (r_baud == BAUD_MAX) begin
          w_bit_end = 1'b1;
          if (r_bit == 4'd9 && r_byte == 4'd10) begin
            w_msg_end = 1'b1;
            // A report on the final edge counts as queued and starts straight away.
            w_state_d = (r_pend || bus.report) ? StConvert : StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Add-3 correction for every BCD digit ahead of the next shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] > 4'd4) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // ASCII digits, d0 at index 0, with optional leading-zero blanking.
  always_comb begin
    for (int i = 0; i < 5; i++) w_chr[i] = {4'h3, r_bcd[4*i +: 4]};
`ifdef COUNTER_UART_BLANK_ZEROS_EN
    begin : blank
      logic w_lead;
      w_lead = 1'b1;
      for (int i = 4; i >= 1; i--) begin
        if (w_lead && r_bcd[4*i +: 4] == 4'd0) w_chr[i] = 8'h20;
        else                                   w_lead   = 1'b0;
      end
    end
`endif
  end

  // Position of the bit that starts on this edge, and the line level it needs.
  always_comb begin
    w_nbit  = r_bit;
    w_nbyte = r_byte;
    if (w_bit_end) begin
      if (r_bit == 4'd9) begin
        w_nbit  = 4'd0;
        w_nbyte = r_byte + 4'd1;
      end else begin
        w_nbit  = r_bit + 4'd1;
      end
    end
    case (w_nbyte)
      4'd0:    w_byte_val = 8'h42;
      4'd1:    w_byte_val = 8'h54;
      4'd2:    w_byte_val = 8'h4E;
      4'd3:    w_byte_val = 8'h3D;
      4'd4:    w_byte_val = w_chr[4];
      4'd5:    w_byte_val = w_chr[3];
      4'd6:    w_byte_val = w_chr[2];
      4'd7:    w_byte_val = w_chr[1];
      4'd8:    w_byte_val = w_chr[0];
      4'd9:    w_byte_val = 8'h0D;
      default: w_byte_val = 8'h0A;
    endcase
    if (w_nbit == 4'd0)      w_tx_d = 1'b0;
    else if (w_nbit == 4'd9) w_tx_d = 1'b1;
    else                     w_tx_d = w_byte_val[3'(w_nbit - 4'd1)];
  end

  // Datapath: pending slot, conversion, serializer and status pulses.
  always_ff @(posedge clk_12m) begin
    if (!rst_n) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_dropped  <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_cnt <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnv      <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
    end else begin
      r_done    <= w_msg_end;
      r_dropped <= r_busy && bus.report && r_pend;

      if (w_msg_end) begin
        // The slot is consumed now; only a report that collides with a full slot refills it.
        r_pend <= r_pend && bus.report;
        if (r_pend && bus.report) r_pend_cnt <= bus.count_in;
      end else if (r_busy && bus.report) begin
        r_pend     <= 1'b1;
        r_pend_cnt <= bus.count_in;
      end

      if (w_start) begin
        r_busy <= 1'b1;
        r_bin  <= bus.count_in;
        r_bcd  <= '0;
        r_cnv  <= '0;
      end else if (w_msg_end) begin
        r_tx   <= 1'b1;
        r_busy <= r_pend || bus.report;
        r_bin  <= r_pend ? r_pend_cnt : bus.count_in;
        r_bcd  <= '0;
        r_cnv  <= '0;
      end else if (r_state == StConvert) begin
        if (w_cnv_done) begin
          r_tx   <= 1'b0;
          r_baud <= '0;
          r_bit  <= '0;
          r_byte <= '0;
        end else begin
          r_bcd <= {w_bcd_adj[18:0], r_bin[15]};
          r_bin <= {r_bin[14:0], 1'b0};
          r_cnv <= r_cnv + 5'd1;
        end
      end else if (r_state == StSend) begin
        r_tx   <= w_tx_d;
        r_bit  <= w_nbit;
        r_byte <= w_nbyte;
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end
    end
  end

  assign bus.uart_tx = r_tx;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.dropped = r_dropped;

endmodule

// File: tb/tb_counter_uart_reporter.sv
// Self-checking bench for counter_uart_reporter: a cycle-accurate UART receiver decodes each
// message and compares it against bytes queued from a division-based digit model.
module tb_counter_uart_reporter;

  localparam int DIV = 12000000 / 115200;
  localparam int MSG = 110 * DIV;

  logic clk_12m = 1'b0;
  logic rst_n;
  int   cyc = 0;

  counter_uart_reporter_if bus ();

  counter_uart_reporter #(
    .CLK_HZ (12000000),
    .BAUD   (115200)
  ) u_dut (
    .clk_12m (clk_12m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_12m = ~clk_12m;
  always @(posedge clk_12m) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int          n_chk = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;
  logic [7:0]  rx_bytes [11];
  int          rx_fall, rx_end, rx_hold_err, rx_frame_err, rx_done_early, rx_drop_cnt;
  logic        rx_timeout, rx_done_end, rx_busy_end;

  task automatic tick();
    @(posedge clk_12m);
    #1;
  endtask

  // Expected message bytes for one count.
  function automatic void push_msg(input int unsigned val);
    logic [7:0]  ch [5];
    int unsigned v = val;
    for (int i = 0; i < 5; i++) begin
      ch[i] = 8'h30 + 8'(v % 10);
      v     = v / 10;
    end
`ifdef COUNTER_UART_BLANK_ZEROS_EN
    begin : blank
      bit lead;
      lead = 1'b1;
      for (int i = 4; i >= 1; i--) begin
        if (lead && ch[i] == 8'h30) ch[i] = 8'h20;
        else                        lead  = 1'b0;
      end
    end
`endif
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'h3D);
    for (int i = 4; i >= 0; i--) exp_q.push_back(ch[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // One-cycle report; count_in is scrambled afterwards to prove it is captured.
  task automatic pulse_report(input logic [15:0] val);
    bus.count_in = val;
    bus.report   = 1'b1;
    tick();
    bus.report   = 1'b0;
    bus.count_in = 16'($urandom);
  endtask

  // Receive one 11-byte frame, sampling the line every cycle so bit lengths are exact.
  task automatic rx_msg();
    int         guard = 0;
    logic       v;
    logic [7:0] b;
    rx_timeout = 1'b0; rx_hold_err = 0; rx_frame_err = 0; rx_done_early = 0; rx_drop_cnt = 0;
    rx_done_end = 1'b0; rx_busy_end = 1'b0;
    for (int k = 0; k < 11; k++) rx_bytes[k] = 8'h00;
    while (bus.uart_tx === 1'b1 && guard < 400) begin
      tick();
      guard++;
    end
    if (bus.uart_tx !== 1'b0) begin
      rx_timeout = 1'b1;
      rx_fall    = cyc;
      rx_end     = cyc;
      return;
    end
    rx_fall = cyc;
    for (int k = 0; k < 11; k++) begin
      b = 8'h00;
      for (int j = 0; j < 10; j++) begin
        v = bus.uart_tx;
        for (int c = 1; c < DIV; c++) begin
          tick();
          if (bus.uart_tx !== v)   rx_hold_err++;
          if (bus.done === 1'b1)    rx_done_early++;
          if (bus.dropped === 1'b1) rx_drop_cnt++;
        end
        if (j == 0 && v !== 1'b0)      rx_frame_err++;
        else if (j == 9 && v !== 1'b1) rx_frame_err++;
        else if (j >= 1 && j <= 8)     b[3'(j - 1)] = v;
        tick();
        if (bus.dropped === 1'b1) rx_drop_cnt++;
        if (!(k == 10 && j == 9) && bus.done === 1'b1) rx_done_early++;
      end
      rx_bytes[k] = b;
    end
    rx_end      = cyc;
    rx_done_end = bus.done;
    rx_busy_end = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.report = 1'b0;
    bus.count_in = 16'h0000;
    repeat (3) tick();
    n_chk++; if (bus.uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", bus.uart_tx);
    else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_chk++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
    else n_pass++;
    n_chk++; if (bus.dropped !== 1'b0) $display("FAIL reset_dropped: got %b want 0", bus.dropped);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  // Count 42, then a report of 11 landing exactly on the final stop-bit edge.
  task automatic test_single_end_edge();
    int e0, end1;
    push_msg(42);
    pulse_report(16'd42);
    e0 = cyc;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL busy_e0: got %b want 1", bus.busy);
    else n_pass++;
    fork
      rx_msg();
      begin
        repeat (17 + MSG - 1) tick();
        push_msg(11);
        pulse_report(16'd11);
        n_chk++; if (bus.dropped !== 1'b0) $display("FAIL edge_dropped: got %b want 0", bus.dropped);
        else n_pass++;
      end
    join
    end1 = rx_end;
    n_chk++; if (rx_timeout) $display("FAIL m42_timeout: got 1 want 0"); else n_pass++;
    n_chk++; if (rx_fall - e0 != 17) $display("FAIL m42_start: got %0d want 17", rx_fall - e0);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m42_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    n_chk++; if (rx_hold_err + rx_frame_err != 0)
      $display("FAIL m42_bits: got %0d bad want 0", rx_hold_err + rx_frame_err);
    else n_pass++;
    n_chk++; if (rx_end - rx_fall != MSG) $display("FAIL m42_len: got %0d want %0d",
      rx_end - rx_fall, MSG);
    else n_pass++;
    n_chk++; if (rx_done_end !== 1'b1 || rx_done_early != 0)
      $display("FAIL m42_done: got end=%b early=%0d want 1/0", rx_done_end, rx_done_early);
    else n_pass++;
    n_chk++; if (rx_busy_end !== 1'b1) $display("FAIL m42_busy_kept: got %b want 1", rx_busy_end);
    else n_pass++;
    rx_msg();
    n_chk++; if (rx_timeout || rx_fall - end1 != 17)
      $display("FAIL m11_start: got %0d want 17", rx_fall - end1);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m11_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    n_chk++; if (rx_done_end !== 1'b1 || rx_busy_end !== 1'b0 || rx_drop_cnt != 0)
      $display("FAIL m11_end: got done=%b busy=%b drop=%0d want 1/0/0",
               rx_done_end, rx_busy_end, rx_drop_cnt);
    else n_pass++;
    tick();
    n_chk++; if (bus.done !== 1'b0) $display("FAIL done_width: got %b want 0", bus.done);
    else n_pass++;
  endtask

  // 65535 with 0 queued behind it.
  task automatic test_extremes();
    int end1;
    push_msg(65535);
    pulse_report(16'hFFFF);
    fork
      rx_msg();
      begin
        repeat (3000) tick();
        push_msg(0);
        pulse_report(16'd0);
      end
    join
    end1 = rx_end;
    n_chk++; if (rx_timeout) $display("FAIL m65535_timeout: got 1 want 0"); else n_pass++;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m65535_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    n_chk++; if (rx_hold_err + rx_frame_err != 0 || rx_drop_cnt != 0)
      $display("FAIL m65535_bits: got bad=%0d drop=%0d want 0/0",
               rx_hold_err + rx_frame_err, rx_drop_cnt);
    else n_pass++;
    rx_msg();
    n_chk++; if (rx_timeout || rx_fall - end1 != 17)
      $display("FAIL m0_start: got %0d want 17", rx_fall - end1);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m0_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    n_chk++; if (rx_hold_err + rx_frame_err != 0 || rx_end - rx_fall != MSG)
      $display("FAIL m0_bits: got bad=%0d len=%0d want 0/%0d",
               rx_hold_err + rx_frame_err, rx_end - rx_fall, MSG);
    else n_pass++;
    n_chk++; if (rx_busy_end !== 1'b0) $display("FAIL m0_busy: got %b want 0", rx_busy_end);
    else n_pass++;
  endtask

  // 7, then 8 and 9 mid-message: 9 overwrites 8 with one dropped pulse.
  task automatic test_drop();
    int end1, act;
    push_msg(7);
    pulse_report(16'd7);
    fork
      rx_msg();
      begin
        repeat (2000) tick();
        pulse_report(16'd8);
        n_chk++; if (bus.dropped !== 1'b0) $display("FAIL drop_first: got %b want 0", bus.dropped);
        else n_pass++;
        repeat (2000) tick();
        pulse_report(16'd9);
        n_chk++; if (bus.dropped !== 1'b1) $display("FAIL drop_pulse: got %b want 1", bus.dropped);
        else n_pass++;
        push_msg(9);
      end
    join
    end1 = rx_end;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m7_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    n_chk++; if (rx_timeout || rx_drop_cnt != 1)
      $display("FAIL m7_drops: got %0d want 1", rx_drop_cnt);
    else n_pass++;
    rx_msg();
    n_chk++; if (rx_timeout || rx_fall - end1 != 17)
      $display("FAIL m9_start: got %0d want 17", rx_fall - end1);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m9_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    act = 0;
    repeat (200) begin
      tick();
      if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) act++;
    end
    n_chk++; if (act != 0) $display("FAIL no_third_msg: got %0d active cycles want 0", act);
    else n_pass++;
  endtask

  // Reset during byte 5 with a request pending, then a clean message for 3.
  task automatic test_reset_mid();
    int e0, act;
    pulse_report(16'd100);
    repeat (2000) tick();
    pulse_report(16'd55);
    repeat (17 + 50 * DIV + 5 - 2001) tick();
    n_chk++; if (bus.uart_tx !== 1'b0) $display("FAIL byte5_start: got %b want 0", bus.uart_tx);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    n_chk++; if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL midreset: got tx=%b busy=%b want 1/0", bus.uart_tx, bus.busy);
    else n_pass++;
    rst_n = 1'b1;
    act = 0;
    repeat (40) begin
      tick();
      if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) act++;
    end
    n_chk++; if (act != 0) $display("FAIL midreset_quiet: got %0d active want 0", act);
    else n_pass++;
    push_msg(3);
    pulse_report(16'd3);
    e0 = cyc;
    rx_msg();
    n_chk++; if (rx_timeout || rx_fall - e0 != 17)
      $display("FAIL m3_start: got %0d want 17", rx_fall - e0);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      exp_b = exp_q.pop_front();
      n_chk++; if (rx_bytes[i] !== exp_b)
        $display("FAIL m3_byte%0d: got %h want %h", i, rx_bytes[i], exp_b);
      else n_pass++;
    end
    n_chk++; if (rx_done_end !== 1'b1 || rx_busy_end !== 1'b0)
      $display("FAIL m3_end: got done=%b busy=%b want 1/0", rx_done_end, rx_busy_end);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_end_edge();
    test_extremes();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
